// File: rtl/h_bridge_driver.sv
// Output stage for a dual H-bridge: registers the IN command, inserts a coast dead-time
// before any new drive code, and gates glitch-free PWM enables onto ENA/ENB.
module h_bridge_driver #(
  parameter int PWM_BITS     = 8,
  parameter int PWM_PRESCALE = 98,
  parameter int DEAD_TICKS   = 50000
) (
  input  logic                i_clock,
  input  logic                i_reset_n,
  input  logic [3:0]          i_cmd_ins,
  input  logic [PWM_BITS-1:0] i_duty,
  output logic [3:0]          o_out_ins,
  output logic                o_en_a,
  output logic                o_en_b,
  output logic                o_busy,
  output logic [1:0]          o_state
);

  localparam int PRE_W = (PWM_PRESCALE > 1) ? $clog2(PWM_PRESCALE) : 1;
  localparam int DC_W  = (DEAD_TICKS > 1) ? $clog2(DEAD_TICKS) : 1;

  localparam logic [3:0] CMD_COAST = 4'b0000;
  localparam logic [3:0] CMD_BRAKE = 4'b1111;

  typedef enum logic [1:0] {
    S_IDLE  = 2'b00,
    S_DRIVE = 2'b01,
    S_DEAD  = 2'b10,
    S_BRAKE = 2'b11
  } state_t;

  state_t            r_state, w_state_nx;
  logic [3:0]        r_cmd_q;
  logic [3:0]        r_target, w_target_nx;
  logic [DC_W-1:0]   r_dead_cnt, w_dead_nx;
  logic [PRE_W-1:0]  r_pre;
  logic [PWM_BITS-1:0] r_pwm_cnt, r_duty_l;
  logic              w_is_brake, w_is_drive, w_pre_wrap, w_pwm, w_dead_done;

  // Stage 1: command register
  always_ff @(posedge i_clock) begin
    if (!i_reset_n) r_cmd_q <= CMD_COAST;
    else            r_cmd_q <= i_cmd_ins;
  end

  always_comb begin
    w_is_brake = (r_cmd_q == CMD_BRAKE);
    w_is_drive = 1'b0;
    case (r_cmd_q)
      4'b0110, 4'b1001, 4'b0101, 4'b1010: w_is_drive = 1'b1;
      default:                            w_is_drive = 1'b0;
    endcase
  end

  assign w_dead_done = (r_dead_cnt == DC_W'(DEAD_TICKS - 1));

  always_ff @(posedge i_clock) begin
    if (!i_reset_n) begin
      r_state    <= S_IDLE;
      r_target   <= CMD_COAST;
      r_dead_cnt <= '0;
    end else begin
      r_state    <= w_state_nx;
      r_target   <= w_target_nx;
      r_dead_cnt <= w_dead_nx;
    end
  end

  // Entering drive from IDLE or BRAKE also goes through dead-time, so the
  // bridge always sees a full coast before any drive code appears.
  always_comb begin
    w_state_nx  = r_state;
    w_target_nx = r_target;
    w_dead_nx   = r_dead_cnt;
    if (w_is_brake) begin
      w_state_nx = S_BRAKE;
    end else if (!w_is_drive) begin
      w_state_nx = S_IDLE;
    end else begin
      case (r_state)
        S_DRIVE: begin
          if (r_cmd_q != r_target) begin
            w_state_nx  = S_DEAD;
            w_target_nx = r_cmd_q;
            w_dead_nx   = '0;
          end
        end
        S_DEAD: begin
          if (r_cmd_q != r_target) begin
            w_target_nx = r_cmd_q;
            w_dead_nx   = '0;
          end else if (w_dead_done) begin
            w_state_nx = S_DRIVE;
          end else begin
            w_dead_nx = r_dead_cnt + DC_W'(1);
          end
        end
        default: begin
          w_state_nx  = S_DEAD;
          w_target_nx = r_cmd_q;
          w_dead_nx   = '0;
        end
      endcase
    end
  end

  // Free-running PWM; duty only latched at the period boundary
  assign w_pre_wrap = (r_pre == PRE_W'(PWM_PRESCALE - 1));

  always_ff @(posedge i_clock) begin
    if (!i_reset_n) begin
      r_pre     <= '0;
      r_pwm_cnt <= '0;
      r_duty_l  <= '0;
    end else if (w_pre_wrap) begin
      r_pre     <= '0;
      r_pwm_cnt <= r_pwm_cnt + PWM_BITS'(1);
      if (r_pwm_cnt == {PWM_BITS{1'b1}}) r_duty_l <= i_duty;
    end else begin
      r_pre <= r_pre + PRE_W'(1);
    end
  end

  assign w_pwm = (r_pwm_cnt < r_duty_l);

  always_comb begin
    o_out_ins = CMD_COAST;
    o_en_a    = 1'b0;
    o_en_b    = 1'b0;
    o_busy    = 1'b0;
    case (r_state)
      S_DRIVE: begin
        o_out_ins = r_target;
        o_en_a    = w_pwm;
        o_en_b    = w_pwm;
      end
      S_BRAKE: begin
        o_out_ins = CMD_BRAKE;
        o_en_a    = 1'b1;
        o_en_b    = 1'b1;
      end
      S_DEAD:  o_busy = 1'b1;
      default: ;
    endcase
  end

  assign o_state = r_state;

endmodule
